// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with busy scoreboard and issue stall
// Optional macro REGFILE_BYPASS_EN enables write-to-read forwarding and rbusy writeback relief.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              use_rs1,
  input  logic              use_rs2,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_wr,
  input  logic              flush,
  output logic              rbusy1,
  output logic              rbusy2,
  output logic              stall,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  logic fwd1, fwd2;
  logic wr_ok, accept, clr;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

`ifdef REGFILE_BYPASS_EN
  assign fwd1 = wen && (waddr == raddr1);
  assign fwd2 = wen && (waddr == raddr2);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // Zero target wins over forwarding so x0 never leaks a written value.
  always_comb begin
    rdata1 = mem_q[raddr1];
    rdata2 = mem_q[raddr2];
    if (is_zero(raddr1))  rdata1 = '0;
    else if (fwd1)        rdata1 = wdata;
    if (is_zero(raddr2))  rdata2 = '0;
    else if (fwd2)        rdata2 = wdata;
  end

  assign rbusy1 = busy_q[raddr1] && !fwd1;
  assign rbusy2 = busy_q[raddr2] && !fwd2;

  // WAW check deliberately looks at the raw busy bit.
  assign stall  = issue_valid && !flush &&
                  ((use_rs1 && rbusy1) || (use_rs2 && rbusy2) || (issue_wr && busy_q[issue_rd]));
  assign accept = issue_valid && !stall && !flush && issue_wr && !is_zero(issue_rd);
  assign wr_ok  = wen && !is_zero(waddr);
  assign clr    = wen && busy_q[waddr];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (wr_ok) mem_d[waddr] = wdata;
  end

  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    if (flush) begin
      busy_d     = '0;
      busy_cnt_d = '0;
    end else begin
      if (accept) busy_d[issue_rd] = 1'b1;
      if (clr)    busy_d[waddr]    = 1'b0;
      busy_cnt_d = busy_cnt_q + {{ADDR_W{1'b0}}, accept} - {{ADDR_W{1'b0}}, clr};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] raddr1, raddr2, waddr, issue_rd;
  logic [DW-1:0] rdata1, rdata2, wdata;
  logic          use_rs1, use_rs2, wen, issue_valid, issue_wr, flush;
  logic          rbusy1, rbusy2, stall;
  logic [AW:0]   busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rstn(rstn),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .use_rs1(use_rs1), .use_rs2(use_rs2),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_wr(issue_wr),
    .flush(flush), .rbusy1(rbusy1), .rbusy2(rbusy2), .stall(stall), .busy_cnt(busy_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wen = 1'b0; issue_valid = 1'b0; issue_wr = 1'b0; flush = 1'b0;
    use_rs1 = 1'b0; use_rs2 = 1'b0;
  endtask

  initial begin
    quiet();
    raddr1 = '0; raddr2 = '0; waddr = '0; wdata = '0; issue_rd = '0;
    rstn = 1'b0;
    wen = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1; wen = 1'b0; raddr1 = 5'd3;
    @(negedge clk);
    check_eq("reset_rdata1", rdata1, 32'h0);
    check_eq("reset_busy_cnt", busy_cnt, 0);
    check_eq("reset_stall", stall, 0);

    // zero register: write and issue to x0 both vanish
    step();
    wen = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd0; raddr1 = 5'd0;
    @(negedge clk);
    check_eq("zero_rdata_same", rdata1, 32'h0);
    check_eq("zero_stall", stall, 0);
    step();
    quiet();
    @(negedge clk);
    check_eq("zero_rdata_after", rdata1, 32'h0);
    check_eq("zero_busy_cnt", busy_cnt, 0);
    check_eq("zero_rbusy1", rbusy1, 0);

    // forwarding (or its absence) on port 2
    step();
    wen = 1'b1; waddr = 5'd5; wdata = 32'hA5A5A5A5; raddr2 = 5'd5;
    @(negedge clk);
    check_eq("fwd_same_cycle", rdata2, BYP ? 32'hA5A5A5A5 : 32'h0);
    step();
    wen = 1'b0;
    @(negedge clk);
    check_eq("fwd_next_cycle", rdata2, 32'hA5A5A5A5);
    check_eq("nonbusy_wb_cnt", busy_cnt, 0);

    // RAW stall
    step();
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd7;
    @(negedge clk);
    check_eq("raw_issue_stall", stall, 0);
    step();
    issue_wr = 1'b0; use_rs1 = 1'b1; raddr1 = 5'd7;
    @(negedge clk);
    check_eq("raw_cnt1", busy_cnt, 1);
    check_eq("raw_stall", stall, 1);
    check_eq("raw_rbusy1", rbusy1, 1);
    step();
    @(negedge clk);
    check_eq("raw_stall_hold", stall, 1);
    step();
    wen = 1'b1; waddr = 5'd7; wdata = 32'h00000077;
    @(negedge clk);
    check_eq("raw_wb_stall", stall, BYP ? 0 : 1);
    check_eq("raw_wb_rbusy1", rbusy1, BYP ? 0 : 1);
    check_eq("raw_wb_rdata1", rdata1, BYP ? 32'h77 : 32'h0);
    step();
    wen = 1'b0;
    @(negedge clk);
    check_eq("raw_after_cnt", busy_cnt, 0);
    check_eq("raw_after_stall", stall, 0);
    check_eq("raw_after_rdata1", rdata1, 32'h77);
    step();
    quiet();

    // WAW with simultaneous writeback
    issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd9;
    step();
    wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
    @(negedge clk);
    check_eq("waw_stall", stall, 1);
    check_eq("waw_cnt_before", busy_cnt, 1);
    step();
    wen = 1'b0;
    @(negedge clk);
    check_eq("waw_cnt_cleared", busy_cnt, 0);
    check_eq("waw_reissue_stall", stall, 0);
    step();
    quiet();
    @(negedge clk);
    check_eq("waw_reissue_cnt", busy_cnt, 1);
    wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
    step();
    wen = 1'b0;
    @(negedge clk);
    check_eq("waw_drain_cnt", busy_cnt, 0);

    // flush discards busy state and the same-cycle issue
    issue_valid = 1'b1; issue_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_rd = 5'(2 + 2 * i);
      step();
    end
    quiet();
    raddr1 = 5'd4;
    @(negedge clk);
    check_eq("flush_pre_cnt", busy_cnt, 3);
    check_eq("flush_pre_rbusy", rbusy1, 1);
    flush = 1'b1; issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 5'd8;
    #1;
    check_eq("flush_stall", stall, 0);
    step();
    quiet();
    @(negedge clk);
    check_eq("flush_cnt", busy_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      raddr1 = 5'(2 + 2 * i);
      #1;
      check_eq($sformatf("flush_rbusy_x%0d", 2 + 2 * i), rbusy1, 0);
    end
    raddr1 = 5'd7; raddr2 = 5'd5;
    #1;
    check_eq("flush_data7", rdata1, 32'h77);
    check_eq("flush_data5", rdata2, 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
